branch_target_predictor: RTL and testbench

- Direct-mapped branch target buffer (BTB) with a 2-bit saturating direction counter per entry.
- Next-generation replacement for the static "predict not-taken, flush on taken" scheme in the 5-stage pipeline.
- Lookup is combinational in IF, addressed by the fetch PC. It supplies the predicted next PC.
- Update comes from ID, where branches and jumps resolve. The block flags mispredicts so the IF/ID flush fires only on a wrong prediction.
- Also keeps saturating branch and mispredict statistics counters.

---
 rtl/branch_target_predictor.sv | 128 ++++++++++++
 tb/tb_branch_target_predictor.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with a 2-bit direction counter per entry.
// Lookup is combinational from fetch PC; updates and statistics come from ID.
module branch_target_predictor #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned ENTRIES  = 16,
  parameter logic [1:0]  CTR_INIT = 2'b01,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [ADDR_W-1:0] pc_f,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [ADDR_W-1:0] pred_target,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_pc,
  input  logic              upd_taken,
  input  logic [ADDR_W-1:0] upd_target,
  input  logic              upd_pred_taken,
  input  logic [ADDR_W-1:0] upd_pred_target,
  input  logic              flush_all,
  output logic              mispredict,
  output logic [CNT_W-1:0]  branch_cnt,
  output logic [CNT_W-1:0]  mispred_cnt
);

  localparam int unsigned IDX_W = $clog2(ENTRIES);
  localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

  logic              valid_q [ENTRIES];
  logic              valid_d [ENTRIES];
  logic [TAG_W-1:0]  tag_q   [ENTRIES];
  logic [TAG_W-1:0]  tag_d   [ENTRIES];
  logic [ADDR_W-1:0] tgt_q   [ENTRIES];
  logic [ADDR_W-1:0] tgt_d   [ENTRIES];
  logic [1:0]        ctr_q   [ENTRIES];
  logic [1:0]        ctr_d   [ENTRIES];

  logic [CNT_W-1:0]  branch_cnt_q, branch_cnt_d;
  logic [CNT_W-1:0]  mispred_cnt_q, mispred_cnt_d;

  logic [IDX_W-1:0]  f_idx;
  logic [TAG_W-1:0]  f_tag;
  logic [IDX_W-1:0]  u_idx;
  logic [TAG_W-1:0]  u_tag;
  logic              u_hit;
  logic              upd_pc_unused;

  // Byte offset of the resolved PC plays no part in indexing or tagging.
  assign upd_pc_unused = ^upd_pc[1:0];

  assign f_idx = pc_f[IDX_W+1:2];
  assign f_tag = pc_f[ADDR_W-1:IDX_W+2];
  assign u_idx = upd_pc[IDX_W+1:2];
  assign u_tag = upd_pc[ADDR_W-1:IDX_W+2];

  // Lookup sees registered state only; same-cycle updates are not bypassed.
  assign pred_hit    = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign pred_taken  = pred_hit && ctr_q[f_idx][1];
  assign pred_target = pred_taken ? tgt_q[f_idx] : pc_f + ADDR_W'(4);

  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  assign mispredict = upd_valid &&
                      ((upd_taken != upd_pred_taken) ||
                       (upd_taken && (upd_target != upd_pred_target)));

  assign branch_cnt  = branch_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

  // Next-state for the BTB array and statistics.
  always_comb begin
    valid_d       = valid_q;
    tag_d         = tag_q;
    tgt_d         = tgt_q;
    ctr_d         = ctr_q;
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;

    if (flush_all) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        valid_d[i] = 1'b0;
      end
    end else if (upd_valid) begin
      if (u_hit) begin
        if (upd_taken) begin
          tgt_d[u_idx] = upd_target;
          if (ctr_q[u_idx] != 2'b11) ctr_d[u_idx] = ctr_q[u_idx] + 2'd1;
        end else begin
          if (ctr_q[u_idx] != 2'b00) ctr_d[u_idx] = ctr_q[u_idx] - 2'd1;
        end
      end else if (upd_taken) begin
        valid_d[u_idx] = 1'b1;
        tag_d[u_idx]   = u_tag;
        tgt_d[u_idx]   = upd_target;
        ctr_d[u_idx]   = 2'b10;
      end
    end

    // Statistics still count during a flush; both saturate.
    if (upd_valid) begin
      if (branch_cnt_q != '1) branch_cnt_d = branch_cnt_q + CNT_W'(1);
      if (mispredict && (mispred_cnt_q != '1)) mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= '0;
        ctr_q[i]   <= CTR_INIT;
      end
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else if (enable) begin
      valid_q       <= valid_d;
      tag_q         <= tag_d;
      tgt_q         <= tgt_d;
      ctr_q         <= ctr_d;
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Scoreboard bench: a 16-bit-counter BTB and a 2-bit-counter BTB share stimulus;
// directed vectors push expected values, a negedge monitor pops and compares.
module tb_branch_target_predictor;

  logic        clk = 1'b0;
  logic        reset, enable, flush_all;
  logic [31:0] pc_f;
  logic        upd_valid, upd_taken, upd_pred_taken;
  logic [31:0] upd_pc, upd_target, upd_pred_target;

  logic        pred_hit, pred_taken, mispredict;
  logic [31:0] pred_target;
  logic [15:0] branch_cnt, mispred_cnt;

  logic        s_hit, unused_s_taken, unused_s_misp;
  logic [31:0] unused_s_target;
  logic [1:0]  s_bcnt, s_mcnt;

  typedef struct {
    logic        hit;
    logic        taken;
    logic [31:0] target;
    logic        misp;
    logic [15:0] bc;
    logic [15:0] mc;
    logic [1:0]  sbc;
    logic [1:0]  smc;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   vec_no   = 0;

  always #5 clk = ~clk;

  branch_target_predictor #(.ADDR_W(32), .ENTRIES(16), .CTR_INIT(2'b01), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .enable(enable), .pc_f(pc_f),
    .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target), .flush_all(flush_all),
    .mispredict(mispredict), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  branch_target_predictor #(.ADDR_W(32), .ENTRIES(16), .CTR_INIT(2'b01), .CNT_W(2)) dut_small (
    .clk(clk), .reset(reset), .enable(enable), .pc_f(pc_f),
    .pred_hit(s_hit), .pred_taken(unused_s_taken), .pred_target(unused_s_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target), .flush_all(flush_all),
    .mispredict(unused_s_misp), .branch_cnt(s_bcnt), .mispred_cnt(s_mcnt)
  );

  task automatic chk(input string name, input int v, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d actual=0x%0h expected=0x%0h", name, v, act, exp);
    end
  endtask

  // Monitor: one expected record per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      vec_no++;
      chk("pred_hit",    vec_no, 32'(pred_hit),    32'(e.hit));
      chk("pred_taken",  vec_no, 32'(pred_taken),  32'(e.taken));
      chk("pred_target", vec_no, pred_target,      e.target);
      chk("mispredict",  vec_no, 32'(mispredict),  32'(e.misp));
      chk("branch_cnt",  vec_no, 32'(branch_cnt),  32'(e.bc));
      chk("mispred_cnt", vec_no, 32'(mispred_cnt), 32'(e.mc));
      chk("small_hit",   vec_no, 32'(s_hit),       32'(e.hit));
      chk("small_bcnt",  vec_no, 32'(s_bcnt),      32'(e.sbc));
      chk("small_mcnt",  vec_no, 32'(s_mcnt),      32'(e.smc));
    end
  end

  // Drive one cycle of stimulus and queue the outputs expected during it.
  task automatic cyc(
    input logic rst, input logic en, input logic fl,
    input logic uv, input logic [31:0] upc, input logic ut, input logic [31:0] utgt,
    input logic upt, input logic [31:0] uptgt, input logic [31:0] pcf,
    input logic e_hit, input logic e_taken, input logic [31:0] e_tgt, input logic e_misp,
    input int e_bc, input int e_mc, input int e_sbc, input int e_smc);
    exp_t e;
    reset = rst; enable = en; flush_all = fl;
    upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utgt;
    upd_pred_taken = upt; upd_pred_target = uptgt; pc_f = pcf;
    e.hit = e_hit; e.taken = e_taken; e.target = e_tgt; e.misp = e_misp;
    e.bc = 16'(e_bc); e.mc = 16'(e_mc); e.sbc = 2'(e_sbc); e.smc = 2'(e_smc);
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  // Lookup-only cycle.
  task automatic look(input logic en, input logic [31:0] pcf,
    input logic e_hit, input logic e_taken, input logic [31:0] e_tgt,
    input int e_bc, input int e_mc, input int e_sbc, input int e_smc);
    cyc(1'b0, en, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, pcf,
        e_hit, e_taken, e_tgt, 1'b0, e_bc, e_mc, e_sbc, e_smc);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; flush_all = 1'b0; pc_f = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
    upd_pred_taken = 1'b0; upd_pred_target = '0;
    @(posedge clk); #1;

    // Post-reset sweep: everything misses, fall-through target.
    for (int i = 0; i < 16; i++) begin
      look(1'b1, 32'(i * 4), 1'b0, 1'b0, 32'(i * 4 + 4), 0, 0, 0, 0);
    end

    // Allocate 0x40 -> 0x100 on a mispredicted taken branch.
    cyc(0,1,0, 1,32'h40,1,32'h100, 0,32'h44, 32'h40, 0,0,32'h44,1, 0,0,0,0);
    look(1'b1, 32'h40, 1,1,32'h100, 1,1,1,1);
    // Two not-taken: 10 -> 01 -> 00.
    cyc(0,1,0, 1,32'h40,0,32'h0, 1,32'h100, 32'h40, 1,1,32'h100,1, 1,1,1,1);
    cyc(0,1,0, 1,32'h40,0,32'h0, 0,32'h44,  32'h40, 1,0,32'h44,0,  2,2,2,2);
    look(1'b1, 32'h40, 1,0,32'h44, 3,2,3,2);
    // Four taken: 00 -> 01 -> 10 -> 11 -> 11 (saturated).
    cyc(0,1,0, 1,32'h40,1,32'h100, 1,32'h100, 32'h40, 1,0,32'h44,0,  3,2,3,2);
    cyc(0,1,0, 1,32'h40,1,32'h100, 1,32'h100, 32'h40, 1,0,32'h44,0,  4,2,3,2);
    cyc(0,1,0, 1,32'h40,1,32'h100, 1,32'h100, 32'h40, 1,1,32'h100,0, 5,2,3,2);
    cyc(0,1,0, 1,32'h40,1,32'h100, 1,32'h100, 32'h40, 1,1,32'h100,0, 6,2,3,2);
    // One not-taken from 11 leaves 10: still predicted taken to 0x100.
    cyc(0,1,0, 1,32'h40,0,32'h0, 1,32'h100, 32'h40, 1,1,32'h100,1, 7,2,3,2);
    look(1'b1, 32'h40, 1,1,32'h100, 8,3,3,3);

    // Aliasing: 0x80 shares index 0 with 0x40 and replaces it.
    cyc(0,1,0, 1,32'h80,1,32'h200, 0,32'h84, 32'h80, 0,0,32'h84,1, 8,3,3,3);
    look(1'b1, 32'h80, 1,1,32'h200, 9,4,3,3);
    look(1'b1, 32'h40, 0,0,32'h44,  9,4,3,3);
    // Not-taken miss at 0xC0 does not allocate.
    cyc(0,1,0, 1,32'hC0,0,32'h0, 0,32'hC4, 32'h80, 1,1,32'h200,0, 9,4,3,3);
    look(1'b1, 32'hC0, 0,0,32'hC4,  10,4,3,3);
    look(1'b1, 32'h80, 1,1,32'h200, 10,4,3,3);

    // Stall: updates ignored, mispredict still live.
    cyc(0,0,0, 1,32'h80,0,32'h0,   1,32'h200, 32'h80, 1,1,32'h200,1, 10,4,3,3);
    cyc(0,0,0, 1,32'h100,1,32'h300, 0,32'h104, 32'h80, 1,1,32'h200,1, 10,4,3,3);
    look(1'b1, 32'h80,  1,1,32'h200, 10,4,3,3);
    look(1'b1, 32'h100, 0,0,32'h104, 10,4,3,3);

    // Second entry at index 1, then flush with a concurrent update.
    cyc(0,1,0, 1,32'h44,1,32'h400, 0,32'h48, 32'h44, 0,0,32'h48,1, 10,4,3,3);
    look(1'b1, 32'h44, 1,1,32'h400, 11,5,3,3);
    cyc(1'b0,1'b1,1'b1, 1,32'h48,1,32'h500, 0,32'h4C, 32'h44, 1,1,32'h400,1, 11,5,3,3);
    look(1'b1, 32'h48, 0,0,32'h4C, 12,6,3,3);
    look(1'b1, 32'h44, 0,0,32'h48, 12,6,3,3);
    look(1'b1, 32'h80, 0,0,32'h84, 12,6,3,3);

    // Reset wins over a simultaneous allocating update.
    cyc(1,1,0, 1,32'h44,1,32'h600, 0,32'h48, 32'h44, 0,0,32'h48,1, 12,6,3,3);
    look(1'b1, 32'h44, 0,0,32'h48, 0,0,0,0);

    // Five mispredicting updates: 2-bit counters stick at 3.
    cyc(0,1,0, 1,32'h8,1,32'h20, 0,32'hC, 32'h8, 0,0,32'hC,1,  0,0,0,0);
    cyc(0,1,0, 1,32'h8,1,32'h20, 0,32'hC, 32'h8, 1,1,32'h20,1, 1,1,1,1);
    cyc(0,1,0, 1,32'h8,1,32'h20, 0,32'hC, 32'h8, 1,1,32'h20,1, 2,2,2,2);
    cyc(0,1,0, 1,32'h8,1,32'h20, 0,32'hC, 32'h8, 1,1,32'h20,1, 3,3,3,3);
    cyc(0,1,0, 1,32'h8,1,32'h20, 0,32'hC, 32'h8, 1,1,32'h20,1, 4,4,3,3);
    look(1'b1, 32'h8, 1,1,32'h20, 5,5,3,3);
    look(1'b1, 32'h8, 1,1,32'h20, 5,5,3,3);

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d pending expected=0 pending", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
